conflict_table: RTL and testbench

CONFLICT_TABLE -- requirements
Module: conflict_table

---
 rtl/ct_pkg.sv | 15 +
 rtl/conflict_table_if.sv | 29 ++
 rtl/ct_prio_enc.sv | 23 ++
 rtl/conflict_table.sv | 94 +++++++++
 tb/tb_conflict_table.sv | 126 ++++++++++++
 5 files changed

// File: rtl/ct_pkg.sv
// Shared defaults and entry layout for the fully associative conflict table.
package ct_pkg;

  localparam int CT_DEPTH      = 16;
  localparam int CT_DATA_WIDTH = 64;
  localparam int CT_HASH_WIDTH = 12;

  typedef struct packed {
    logic                     valid;
    logic [CT_DATA_WIDTH-1:0] key;
    logic [CT_HASH_WIDTH-1:0] hash;
    logic [CT_HASH_WIDTH-1:0] map;
  } ct_entry_t;

endpackage

// File: rtl/conflict_table_if.sv
// Request/response bundle between a table client (master) and the conflict table (slave).
interface conflict_table_if
  import ct_pkg::*;
#(
  parameter int DATA_WIDTH = CT_DATA_WIDTH,
  parameter int HASH_WIDTH = CT_HASH_WIDTH
);

  logic                  cs;
  logic                  we;
  logic [DATA_WIDTH-1:0] data;
  logic [HASH_WIDTH-1:0] hash_in;
  logic [HASH_WIDTH-1:0] map_in;
  logic                  match;
  logic [HASH_WIDTH-1:0] hash_out;
  logic [HASH_WIDTH-1:0] map_out;
  logic                  ct_full;

  modport master (
    output cs, we, data, hash_in, map_in,
    input  match, hash_out, map_out, ct_full
  );

  modport slave (
    input  cs, we, data, hash_in, map_in,
    output match, hash_out, map_out, ct_full
  );

endinterface

// File: rtl/ct_prio_enc.sv
// Lowest-index priority encoder: reports whether any request is set and the index of the lowest one.
module ct_prio_enc #(
  parameter int N = 16,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          hit,
  output logic [IW-1:0] idx
);

  // Scanning downward lets the lowest set index win by overwriting last.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/conflict_table.sv
// Fully associative key -> {hash, map} table with one-cycle registered lookup and in-place overwrite.
module conflict_table
  import ct_pkg::*;
#(
  parameter int DEPTH      = CT_DEPTH,
  parameter int DATA_WIDTH = CT_DATA_WIDTH,
  parameter int HASH_WIDTH = CT_HASH_WIDTH
) (
  input logic             clk,
  input logic             rst,
  conflict_table_if.slave bus
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DEPTH-1:0]      valid_reg;
  logic [DATA_WIDTH-1:0] key_reg  [DEPTH];
  logic [HASH_WIDTH-1:0] hash_reg [DEPTH];
  logic [HASH_WIDTH-1:0] map_reg  [DEPTH];
  logic [CW-1:0]         count_reg;
  logic                  full_reg;
  logic                  match_reg;
  logic [HASH_WIDTH-1:0] hash_out_reg;
  logic [HASH_WIDTH-1:0] map_out_reg;

  logic [DEPTH-1:0] hit_vec;
  logic [DEPTH-1:0] free_vec;
  logic             hit_any;
  logic [IW-1:0]    hit_idx;
  logic             free_any;
  logic [IW-1:0]    free_idx;

  // Invalid slots are masked out so stale keys (including all-zero) never hit.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign hit_vec[gi]  = valid_reg[gi] && (key_reg[gi] == bus.data);
      assign free_vec[gi] = ~valid_reg[gi];
    end
  endgenerate

  ct_prio_enc #(.N(DEPTH)) u_hit_enc (
    .req (hit_vec),
    .hit (hit_any),
    .idx (hit_idx)
  );

  ct_prio_enc #(.N(DEPTH)) u_free_enc (
    .req (free_vec),
    .hit (free_any),
    .idx (free_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg    <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      match_reg    <= 1'b0;
      hash_out_reg <= '0;
      map_out_reg  <= '0;
    end else begin
      match_reg <= 1'b0;
      if (bus.cs && !bus.we) begin
        if (hit_any) begin
          match_reg    <= 1'b1;
          hash_out_reg <= hash_reg[hit_idx];
          map_out_reg  <= map_reg[hit_idx];
        end
      end else if (bus.cs && bus.we) begin
        if (hit_any) begin
          hash_reg[hit_idx] <= bus.hash_in;
          map_reg[hit_idx]  <= bus.map_in;
        end else if (free_any) begin
          // A new key takes the lowest free slot; with no free slot the write is dropped.
          valid_reg[free_idx] <= 1'b1;
          key_reg[free_idx]   <= bus.data;
          hash_reg[free_idx]  <= bus.hash_in;
          map_reg[free_idx]   <= bus.map_in;
          count_reg           <= count_reg + 1'b1;
          full_reg            <= ((count_reg + 1'b1) == DEPTH_C);
        end
      end
    end
  end

  assign bus.match    = match_reg;
  assign bus.hash_out = hash_out_reg;
  assign bus.map_out  = map_out_reg;
  assign bus.ct_full  = full_reg;

endmodule

// File: tb/tb_conflict_table.sv
// Directed bench for conflict_table: reset, write/lookup, miss, fill/overflow, overwrite, mid-sequence reset.
module tb_conflict_table;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;

  conflict_table_if bus_if ();

  conflict_table dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock edge per transaction; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic c, input logic w, input logic [63:0] d,
                      input logic [11:0] h, input logic [11:0] m);
    bus_if.cs      = c;
    bus_if.we      = w;
    bus_if.data    = d;
    bus_if.hash_in = h;
    bus_if.map_in  = m;
    @(posedge clk);
    #1;
    $display("txn rst=%0b cs=%0b we=%0b data=%h hash_in=%h map_in=%h -> match=%0b hash_out=%h map_out=%h ct_full=%0b",
             rst, c, w, d, h, m, bus_if.match, bus_if.hash_out, bus_if.map_out, bus_if.ct_full);
  endtask

  initial begin
    bus_if.cs = 1'b0; bus_if.we = 1'b0; bus_if.data = '0;
    bus_if.hash_in = '0; bus_if.map_in = '0;
    rst = 1'b1;
    step(1'b0, 1'b0, 64'h0, 12'h0, 12'h0);
    step(1'b0, 1'b0, 64'h0, 12'h0, 12'h0);
    rst = 1'b0;

    // Reset state via a lookup on an empty table
    step(1'b1, 1'b0, 64'h41, 12'h0, 12'h0);
    chk("rst_match", {63'd0, bus_if.match}, 64'd0);
    chk("rst_hash", {52'd0, bus_if.hash_out}, 64'h0);
    chk("rst_map", {52'd0, bus_if.map_out}, 64'h0);
    chk("rst_full", {63'd0, bus_if.ct_full}, 64'd0);

    // Write, then look it up on the next cycle
    step(1'b1, 1'b1, 64'h4142, 12'h123, 12'h105);
    chk("wr_match", {63'd0, bus_if.match}, 64'd0);
    step(1'b1, 1'b0, 64'h4142, 12'h0, 12'h0);
    chk("lk_match", {63'd0, bus_if.match}, 64'd1);
    chk("lk_hash", {52'd0, bus_if.hash_out}, 64'h123);
    chk("lk_map", {52'd0, bus_if.map_out}, 64'h105);

    // Miss holds previous hash/map
    step(1'b1, 1'b0, 64'h4143, 12'h0, 12'h0);
    chk("miss_match", {63'd0, bus_if.match}, 64'd0);
    chk("miss_hash", {52'd0, bus_if.hash_out}, 64'h123);
    chk("miss_map", {52'd0, bus_if.map_out}, 64'h105);

    // Idle cycle after a hit clears match
    step(1'b1, 1'b0, 64'h4142, 12'h0, 12'h0);
    chk("hit2_match", {63'd0, bus_if.match}, 64'd1);
    step(1'b0, 1'b0, 64'h4142, 12'h0, 12'h0);
    chk("idle_match", {63'd0, bus_if.match}, 64'd0);
    chk("idle_hash", {52'd0, bus_if.hash_out}, 64'h123);

    // Fill the remaining 15 slots; full rises on the 16th write edge
    for (int i = 1; i <= 15; i++) begin
      step(1'b1, 1'b1, 64'h1000 + 64'(i), 12'(i), 12'(i + 16));
      chk($sformatf("fill%0d_full", i), {63'd0, bus_if.ct_full}, (i == 15) ? 64'd1 : 64'd0);
    end

    // Overflow: a 17th key is dropped
    step(1'b1, 1'b1, 64'h9999, 12'hABC, 12'hDEF);
    chk("ovf_full", {63'd0, bus_if.ct_full}, 64'd1);
    step(1'b1, 1'b0, 64'h9999, 12'h0, 12'h0);
    chk("ovf_match", {63'd0, bus_if.match}, 64'd0);
    chk("ovf_hash", {52'd0, bus_if.hash_out}, 64'h123);
    step(1'b1, 1'b0, 64'h100F, 12'h0, 12'h0);
    chk("last_match", {63'd0, bus_if.match}, 64'd1);
    chk("last_hash", {52'd0, bus_if.hash_out}, 64'h00F);
    chk("last_map", {52'd0, bus_if.map_out}, 64'h01F);

    // Overwrite an existing key on a full table
    step(1'b1, 1'b1, 64'h4142, 12'h200, 12'h105);
    chk("ow_full", {63'd0, bus_if.ct_full}, 64'd1);
    step(1'b1, 1'b0, 64'h4142, 12'h0, 12'h0);
    chk("ow_match", {63'd0, bus_if.match}, 64'd1);
    chk("ow_hash", {52'd0, bus_if.hash_out}, 64'h200);
    chk("ow_map", {52'd0, bus_if.map_out}, 64'h105);

    // Mid-operation reset with a concurrent write
    rst = 1'b1;
    step(1'b1, 1'b1, 64'h5555, 12'h055, 12'h066);
    rst = 1'b0;
    chk("mrst_match", {63'd0, bus_if.match}, 64'd0);
    chk("mrst_hash", {52'd0, bus_if.hash_out}, 64'h0);
    chk("mrst_map", {52'd0, bus_if.map_out}, 64'h0);
    chk("mrst_full", {63'd0, bus_if.ct_full}, 64'd0);
    step(1'b1, 1'b0, 64'h5555, 12'h0, 12'h0);
    chk("mrst_lk5555", {63'd0, bus_if.match}, 64'd0);
    step(1'b1, 1'b0, 64'h4142, 12'h0, 12'h0);
    chk("mrst_lk4142", {63'd0, bus_if.match}, 64'd0);

    // All-zero key only hits once stored
    step(1'b1, 1'b0, 64'h0, 12'h0, 12'h0);
    chk("zero_miss", {63'd0, bus_if.match}, 64'd0);
    step(1'b1, 1'b1, 64'h0, 12'h007, 12'h009);
    step(1'b1, 1'b0, 64'h0, 12'h0, 12'h0);
    chk("zero_match", {63'd0, bus_if.match}, 64'd1);
    chk("zero_hash", {52'd0, bus_if.hash_out}, 64'h007);
    chk("zero_map", {52'd0, bus_if.map_out}, 64'h009);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
